// File: rtl/counter.sv
// rtl/counter.sv - free-running N-bit up-counter with terminal-count flag
//
// Purpose:
//   General-purpose timebase/prescaler primitive. Increments on every rising
//   clk edge, wraps modulo 2^N, and decodes the all-ones state as max_tick so
//   downstream logic can use it as a periodic tick or enable. No enable, load
//   or down-count; reset is the only control.
//
// Parameters:
//   N         counter width in bits, legal range 1..32 (default 10)
//
// Ports:
//   clk       in   1  single clock, all state changes on the rising edge
//   rst       in   1  asynchronous active-high reset, clears the count
//   q         out  N  current count, driven straight from the count register
//   max_tick  out  1  high while q is all ones (combinational decode of q)
//   min_tick  out  1  high while q is zero; only present when the macro
//                     COUNTER_MIN_TICK_EN is defined
//
// Configuration:
//   COUNTER_MIN_TICK_EN  adds the min_tick output; counting is unchanged.

module counter #(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst,
`ifdef COUNTER_MIN_TICK_EN
  output logic         min_tick,
`endif
  output logic         max_tick,
  output logic [N-1:0] q
);

  logic [N-1:0] count_reg;
  logic [N-1:0] count_next;

  // Truncating add: all-ones rolls straight to zero, no carry-out kept.
  assign count_next = count_reg + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign q = count_reg;

  // Pure decode with no register stage: the flag rises in the same cycle q
  // reaches all ones and falls with the wrap (or immediately on reset).
  assign max_tick = &count_reg;

`ifdef COUNTER_MIN_TICK_EN
  assign min_tick = (count_reg == '0);
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for counter (N=10)

module tb_counter;

  localparam int N = 10;

  logic         test_clk;
  logic         rst;
  logic         max_tick;
  logic [N-1:0] q;
`ifdef COUNTER_MIN_TICK_EN
  logic         min_tick;
`endif

  int checks;
  int failures;
  int unsigned model;

  counter #(.N(N)) dut (
    .clk      (test_clk),
    .rst      (rst),
`ifdef COUNTER_MIN_TICK_EN
    .min_tick (min_tick),
`endif
    .max_tick (max_tick),
    .q        (q)
  );

  initial test_clk = 1'b0;
  always #5 test_clk = ~test_clk;

  typedef struct {
    int unsigned edges;
    logic [N-1:0] exp_q;
    logic         exp_max;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Checks all outputs against the bench's own count model.
  task automatic check_state(input string tag);
    check({tag, " q"}, 32'(q), 32'(model % 1024));
    check({tag, " max_tick"}, 32'(max_tick), 32'((model % 1024) == 1023));
`ifdef COUNTER_MIN_TICK_EN
    check({tag, " min_tick"}, 32'(min_tick), 32'((model % 1024) == 0));
`endif
  endtask

  // Holds reset over several rising edges, then releases it away from an edge.
  task automatic do_reset(input int cycles);
    @(negedge test_clk);
    rst = 1'b1;
    model = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge test_clk);
      @(negedge test_clk);
      check_state($sformatf("reset_hold[%0d]", c));
    end
    rst = 1'b0;
  endtask

  // Runs n rising edges, sampling every edge on the following falling edge.
  task automatic run_edges(input int unsigned n, input string tag);
    for (int unsigned e = 0; e < n; e++) begin
      @(posedge test_clk);
      model++;
      @(negedge test_clk);
      if (((model % 1024) == 1023) || ((model % 1024) == 0) || (e == n - 1))
        check_state($sformatf("%s edge%0d", tag, model));
      else begin
        checks++;
        if (max_tick !== 1'b0) begin
          failures++;
          $display("FAIL %s edge%0d max_tick actual=%0b expected=0", tag, model, max_tick);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model    = 0;
    rst      = 1'b1;

    vecs[0]  = '{0,    10'd0,    1'b0};
    vecs[1]  = '{1,    10'd1,    1'b0};
    vecs[2]  = '{37,   10'd37,   1'b0};
    vecs[3]  = '{1022, 10'd1022, 1'b0};
    vecs[4]  = '{1023, 10'h3FF,  1'b1};
    vecs[5]  = '{1024, 10'd0,    1'b0};
    vecs[6]  = '{1025, 10'd1,    1'b0};
    vecs[7]  = '{2047, 10'h3FF,  1'b1};
    vecs[8]  = '{2048, 10'd0,    1'b0};
    vecs[9]  = '{3000, 10'd952,  1'b0};
    vecs[10] = '{4095, 10'h3FF,  1'b1};

    // Asynchronous reset at time zero, before any clock edge.
    #1;
    check("initial_reset q", 32'(q), 32'd0);
    check("initial_reset max_tick", 32'(max_tick), 32'd0);

    do_reset(10);

    for (int i = 0; i < 11; i++) begin
      if (i != 0) do_reset(2);
      run_edges(vecs[i].edges, $sformatf("vec%0d", i));
      check($sformatf("vec%0d final q", i), 32'(q), 32'(vecs[i].exp_q));
      check($sformatf("vec%0d final max_tick", i), 32'(max_tick), 32'(vecs[i].exp_max));
    end

    // Random run lengths with a reset between each.
    for (int r = 0; r < 10; r++) begin
      int unsigned n;
      n = $urandom_range(0, 4095);
      do_reset(1);
      run_edges(n, $sformatf("rand%0d", r));
      check($sformatf("rand%0d n=%0d q", r, n), 32'(q), n % 1024);
    end

    // Asynchronous reset mid-cycle at q=500.
    do_reset(1);
    run_edges(500, "mid");
    check("mid q before reset", 32'(q), 32'd500);
    #2 rst = 1'b1;
    #1;
    check("mid async q", 32'(q), 32'd0);
    check("mid async max_tick", 32'(max_tick), 32'd0);
    model = 0;
    @(posedge test_clk);
    @(negedge test_clk);
    check("mid edge under reset q", 32'(q), 32'd0);
    rst = 1'b0;
    run_edges(3, "mid_after");
    check("mid after 3 edges q", 32'(q), 32'd3);

    // Asynchronous reset while at all ones: max_tick must drop at once.
    do_reset(1);
    run_edges(1023, "top");
    check("top max_tick before reset", 32'(max_tick), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("top async q", 32'(q), 32'd0);
    check("top async max_tick", 32'(max_tick), 32'd0);
`ifdef COUNTER_MIN_TICK_EN
    check("top async min_tick", 32'(min_tick), 32'd1);
`endif
    rst = 1'b0;
    model = 0;
    run_edges(1, "top_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
